// File: rtl/prog_loader.sv
// Byte-serial program loader: packs a valid/ready byte stream MSB-first into 32-bit
// instruction words and writes them from address 0. Optional trailing checksum byte: CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start; CPU released
// RECV  | accepting bytes of the current word
// WRITE | one-cycle write of the assembled word
// CHK   | accepting the checksum byte (CHECKSUM_EN only)
// DONE  | one-cycle done pulse
module prog_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 32
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          start,
    input  logic [AW:0]   load_len,
    input  logic          abort,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [IW-1:0] mem_wdata,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
`ifdef CHECKSUM_EN
        CHK   = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_W   = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    state_t        state_q, state_d;
    logic [IW-1:0] shreg_q, shreg_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   len_q, len_d;
    logic          err_d;
    logic          byte_take;
    logic          last_word;
`ifdef CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    assign byte_take = byte_valid & byte_ready;
    assign last_word = (({1'b0, addr_q} + ONE_W) == len_q);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        err_d   = err;
`ifdef CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (load_len == '0 || load_len > DEPTH_W) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RECV;
                        addr_d  = '0;
                        bcnt_d  = '0;
                        len_d   = load_len;
                        err_d   = 1'b0;
`ifdef CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
            end
            RECV: begin
                if (abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (byte_take) begin
                    shreg_d = {shreg_q[IW-9:0], byte_in};
                    bcnt_d  = bcnt_q + 2'd1;
`ifdef CHECKSUM_EN
                    csum_d  = csum_q ^ byte_in;
`endif
                    if (bcnt_q == 2'd3) state_d = WRITE;
                end
            end
            WRITE: begin
                // the write itself is already on the registered strobe this cycle
                if (abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (last_word) begin
`ifdef CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    addr_d  = addr_q + ONE_A;
                    bcnt_d  = '0;
                    state_d = RECV;
                end
            end
`ifdef CHECKSUM_EN
            CHK: begin
                if (abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (byte_take) begin
                    if (byte_in != csum_q) err_d = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bcnt_q     <= '0;
            addr_q     <= '0;
            len_q      <= '0;
`ifdef CHECKSUM_EN
            csum_q     <= '0;
`endif
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcnt_q     <= bcnt_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
`ifdef CHECKSUM_EN
            csum_q     <= csum_d;
            byte_ready <= (state_d == RECV) || (state_d == CHK);
`else
            byte_ready <= (state_d == RECV);
`endif
            // outputs are decoded from the next state so they line up with it
            mem_we     <= (state_d == WRITE);
            if (state_d == WRITE) begin
                mem_addr  <= addr_d;
                mem_wdata <= shreg_d;
            end
            cpu_hold   <= (state_d != IDLE);
            busy       <= (state_d != IDLE);
            done       <= (state_d == DONE);
            err        <= err_d;
        end
    end

endmodule
